// File: rtl/q3c_frame_ctrl_pkg.sv
// Shared definitions for the q3c frame sequencer.
// Covers the symbol-state codes, the control states and the symbol-machine step/output functions.
package q3c_pkg;

    localparam int DEF_CNT_W = 8;

    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b010;
    localparam logic [2:0] S3 = 3'b011;
    localparam logic [2:0] S4 = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } ctrl_state_t;

    // Codes 101-111 cannot be reached, but they still map back to S0.
    function automatic logic [2:0] q3c_next(input logic [2:0] y, input logic x);
        logic [2:0] y_n;
        case (y)
            S0:      y_n = x ? S1 : S0;
            S1:      y_n = x ? S4 : S1;
            S2:      y_n = x ? S1 : S2;
            S3:      y_n = x ? S2 : S1;
            S4:      y_n = x ? S4 : S3;
            default: y_n = S0;
        endcase
        return y_n;
    endfunction

    function automatic logic q3c_z(input logic [2:0] y);
        return (y == S3) || (y == S4);
    endfunction

endpackage

// File: rtl/q3c_frame_ctrl_if.sv
// Symbol/frame bundle between the source (master) and the frame controller (slave).
interface q3c_frame_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic [CNT_W-1:0] len;
    logic             abort;
    logic             x_valid;
    logic             x;
    logic             x_ready;
    logic [2:0]       y;
    logic             z;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] z_count;

    modport master (
        output start, len, abort, x_valid, x,
        input  x_ready, y, z, busy, done, aborted, z_count
    );

    modport slave (
        input  start, len, abort, x_valid, x,
        output x_ready, y, z, busy, done, aborted, z_count
    );
endinterface

// File: rtl/q3c_frame_ctrl_next_state.sv
// Combinational step of the q3c symbol machine: gives the next state and its Moore output.
module q3c_next_state
    import q3c_pkg::*;
(
    input  logic [2:0] y,
    input  logic       x,
    output logic [2:0] y_next,
    output logic       z_next
);
    always_comb begin
        y_next = q3c_next(y, x);
        z_next = q3c_z(y_next);
    end
endmodule

// File: rtl/q3c_frame_ctrl.sv
// Frame sequencer: launches a frame, steps the symbol machine once per accepted x,
// and reports completion, abort and the number of steps landing in a z-high state.
module q3c_frame_ctrl
    import q3c_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    q3c_frame_ctrl_if.slave bus
);
    ctrl_state_t      state_reg, state_next;
    logic [2:0]       y_reg, y_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [CNT_W-1:0] z_count_reg, z_count_next;

    logic [2:0] step_y;
    logic       step_z;

    q3c_next_state u_next_state (
        .y      (y_reg),
        .x      (bus.x),
        .y_next (step_y),
        .z_next (step_z)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            y_reg         <= S0;
            remaining_reg <= '0;
            z_count_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            y_reg         <= y_next;
            remaining_reg <= remaining_next;
            z_count_reg   <= z_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        y_next         = y_reg;
        remaining_next = remaining_reg;
        z_count_next   = z_count_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    y_next       = S0;
                    z_count_next = '0;
                    if (bus.len != '0) begin
                        remaining_next = bus.len;
                        state_next     = RUN;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                // Abort wins over a symbol offered in the same cycle.
                if (bus.abort) begin
                    state_next = ABORT;
                end else if (bus.x_valid) begin
                    y_next         = step_y;
                    remaining_next = remaining_reg - CNT_W'(1);
                    z_count_next   = z_count_reg + CNT_W'(step_z);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.x_ready = (state_reg == RUN) && !bus.abort;
    assign bus.busy    = (state_reg == RUN);
    assign bus.done    = (state_reg == DONE);
    assign bus.aborted = (state_reg == ABORT);
    assign bus.y       = y_reg;
    assign bus.z       = q3c_z(y_reg);
    assign bus.z_count = z_count_reg;

endmodule

// File: doc/q3c_frame_ctrl.md
# q3c_frame_ctrl

Frame-level sequencer for the five-state q3c symbol machine (states 000–100, input x, Moore output z). It owns the 3-bit state register and applies one next-state step per accepted x symbol over a valid/ready handshake. A frame is launched with `start`/`len`, and the block reports completion, abort and the number of z-high steps. It sits between a bit-serial symbol source and downstream logic that consumes `y`/`z` and per-frame statistics.

## Interface
- CNT_W, 8, width of `len`, the remaining-symbol counter and `z_count`
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  launch a frame; sampled only in IDLE
- len  in  CNT_W  number of symbols in the frame; captured with `start`
- abort  in  1  terminate the current frame; effective only in RUN
- x_valid  in  1  symbol x is valid
- x  in  1  symbol value
- x_ready  out  1  block accepts x this cycle
- y  out  3  current symbol-machine state (registered)
- z  out  1  Moore output of `y`
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when a frame completes normally
- aborted  out  1  one-cycle pulse when a frame is aborted
- z_count  out  CNT_W  count of accepted steps whose next state has z=1

## Operation
- Symbol next-state map (y,x → y'):
  - 000: 0→000, 1→001
  - 001: 0→001, 1→100
  - 010: 0→010, 1→001
  - 011: 0→001, 1→010
  - 100: 0→011, 1→100
  - 101–111: unreachable; next state 000, z=0 (defined, not don't-care).
- z=1 iff y ∈ {011, 100}; otherwise 0.
- Control FSM states:
  - IDLE → RUN on `start` with `len`≠0. This clears `y` to 000 and `z_count` to 0, and loads `remaining` with `len`.
  - IDLE → DONE on `start` with `len`=0. This clears `y` and `z_count`.
  - RUN → DONE on accept when `remaining`=1.
  - RUN → ABORT on `abort`.
  - DONE → IDLE unconditionally; `done`=1 while in DONE.
  - ABORT → IDLE unconditionally; `aborted`=1 while in ABORT.
- Handshake and counting:
  - `x_ready` = (state==RUN) && !`abort`.
  - Accept = `x_valid` && `x_ready`.
  - On accept: `y` ← y'; `remaining` decrements; `z_count` increments if z(y')=1.
  - No accept means `y`, `remaining` and `z_count` hold.
- `busy` = (state==RUN).
- `start` outside IDLE is ignored; `len` is not re-captured.
- Abort has priority over a simultaneous `x_valid`: no symbol is consumed and `y` holds its last value.
- `y`, `z` and `z_count` hold after DONE/ABORT until the next `start`.
- `z_count` ≤ `len`, so it cannot overflow; no saturation logic is needed.

## Timing
- Reset values (all outputs and internal registers):
  - control state IDLE, `y`=000, `z`=0, `z_count`=0, `remaining`=0
  - `busy`=0, `x_ready`=0, `done`=0, `aborted`=0
- Reset mid-frame returns to IDLE with the above values; no `done` or `aborted` pulse.
- Start and first accept:
  - `start` at cycle N → `busy`=1 and `x_ready`=1 at N+1.
  - The earliest accept is at N+1; its y' is visible at N+2.
- Final accept at cycle M → `done`=1 and `busy`=0 at M+1; IDLE at M+2. The next `start` is accepted at M+2.
- `len`=0: `start` at N → `done`=1 at N+1, `busy` never asserts.
- `abort` at cycle A in RUN → `aborted`=1 at A+1; IDLE at A+2.
- `z` depends on `y` only, so it updates in the same cycle as `y`.
- Throughput: one symbol per cycle with `x_valid` held high.

## Structure
- Package `q3c_pkg` holds:
  - symbol-state localparams S0=3'b000 … S4=3'b100
  - control enum {IDLE, RUN, DONE, ABORT}
  - function `q3c_next(y, x)` returning y'
  - function `q3c_z(y)`
- Sub-module `q3c_next_state`: purely combinational (y, x → y', z_next). It is instantiated once, and its z_next is the z of y' used to decide the `z_count` increment.
- Top level holds: control FSM, `remaining` counter, `y` register, `z_count` register.

## Test plan
- Basic frame: `len`=3, x=1,1,0 back-to-back.
  - `y` steps 000→001→100→011.
  - `z` = 0,1,1 after each step; `z_count`=2.
  - `done` pulses one cycle after the 3rd accept.
- Back-pressure: `len`=4, x=0,1,0,1 with `x_valid` low for 2 cycles between every symbol.
  - `y` ends at 100, `z_count`=1.
  - `y` does not change during the gaps; `done` pulses only after the 4th accept.
- Zero length: `len`=0.
  - `done` pulses at start+1; `busy` and `x_ready` stay 0; `y`=000.
- Abort: `len`=5, two accepts (x=1,1 → `y`=100), then `abort` asserted together with `x_valid`.
  - Symbol not consumed; `y` stays 100; `z_count`=1.
  - `aborted` pulses; `done` never pulses.
- Start while busy: `start` with `len`=7 during a `len`=2 frame.
  - Ignored; the frame completes after 2 accepts.
  - A new `start` two cycles after `done` launches a frame with `y` and `z_count` cleared.
- Reset mid-frame: `reset` during RUN with `y`=011.
  - Next cycle: `y`=000, `z`=0, `busy`=0, `z_count`=0, no `done` or `aborted` pulse.
